// File: rtl/i_merge_pkg.sv
// rtl/i_merge_pkg.sv - shared interconnect constants and header route helper
package i_merge_pkg;

   localparam int DATA_W    = 64;
   localparam int BEAT_W    = DATA_W + 1;
   localparam int ROUTE_MSB = 55;
   localparam int ROUTE_LSB = 48;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } merge_state_t;

   // Push one port bit into the route field; the oldest hop falls off the top.
   function automatic logic [DATA_W-1:0] push_route(input logic [DATA_W-1:0] hdr, input logic port);
      logic [DATA_W-1:0] r;
      r = hdr;
      r[ROUTE_MSB:ROUTE_LSB] = {hdr[ROUTE_MSB-1:ROUTE_LSB], port};
      return r;
   endfunction

endpackage

// File: rtl/i_merge_double_latch.sv
// rtl/i_merge_double_latch.sv - 2-entry skid buffer, ready derived from occupancy only
module i_merge_double_latch #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_tdata,
   input  logic             in_tvalid,
   output logic             in_tready,
   output logic [WIDTH-1:0] out_tdata,
   output logic             out_tvalid,
   input  logic             out_tready
);

   logic [WIDTH-1:0] entry0;
   logic [WIDTH-1:0] entry1;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign in_tready  = (count != 2'd2);
   assign out_tvalid = (count != 2'd0);
   assign out_tdata  = entry0;
   assign push       = in_tvalid && in_tready;
   assign pop        = out_tvalid && out_tready;

   // entry0 is always the head; entry1 only holds data when two beats are queued
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) entry0 <= in_tdata;
               else               entry1 <= in_tdata;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  entry0 <= in_tdata;
               end else begin
                  entry0 <= entry1;
                  entry1 <= in_tdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/i_merge.sv
// rtl/i_merge.sv - two-to-one packet merge with optional route tagging of headers
module i_merge
   import i_merge_pkg::*;
#(
   parameter bit ADD_ROUTE = 1'b1,
   parameter bit RR        = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              I0_TVALID,
   output logic              I0_TREADY,
   input  logic [DATA_W-1:0] I0_TDATA,
   input  logic              I0_TLAST,
   input  logic              I1_TVALID,
   output logic              I1_TREADY,
   input  logic [DATA_W-1:0] I1_TDATA,
   input  logic              I1_TLAST,
   output logic              O_TVALID,
   input  logic              O_TREADY,
   output logic [DATA_W-1:0] O_TDATA,
   output logic              O_TLAST
);

   merge_state_t      state;
   logic              owner;
   logic              last_grant;
   logic              grant;
   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] beat_data;
   logic              buf_ready;
   logic              buf_valid;
   logic              can_accept;
   logic              accept;

   always_comb begin
      grant = 1'b0;
      if (state == ST_BUSY)
         grant = owner;
      else if (I0_TVALID && I1_TVALID)
         grant = RR ? ~last_grant : 1'b0;
      else
         grant = I1_TVALID;

      sel_valid = grant ? I1_TVALID : I0_TVALID;
      sel_last  = grant ? I1_TLAST  : I0_TLAST;
      sel_data  = grant ? I1_TDATA  : I0_TDATA;

      // only a beat taken between packets is a header
      beat_data = sel_data;
      if (ADD_ROUTE && state == ST_IDLE)
         beat_data = push_route(sel_data, grant);
   end

   assign can_accept = buf_ready && !reset;
   assign I0_TREADY  = can_accept && !grant;
   assign I1_TREADY  = can_accept && grant;
   assign accept     = sel_valid && can_accept;
   assign O_TVALID   = buf_valid && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            if (!sel_last) begin
               state <= ST_BUSY;
               owner <= grant;
            end else begin
               last_grant <= grant;
            end
         end else if (sel_last) begin
            state      <= ST_IDLE;
            last_grant <= owner;
         end
      end
   end

   i_merge_double_latch #(
      .WIDTH (BEAT_W)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .in_tdata   ({sel_last, beat_data}),
      .in_tvalid  (sel_valid),
      .in_tready  (buf_ready),
      .out_tdata  ({O_TLAST, O_TDATA}),
      .out_tvalid (buf_valid),
      .out_tready (O_TREADY)
   );

endmodule
